// File: rtl/alu_sequencer.sv
// Instruction sequencer driving the register-file + ALU datapath over a valid/ready handshake.
// Optional retired-instruction counter enabled by defining ALU_SEQ_RETIRE_COUNT_EN.
module alu_sequencer #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  input  logic [7:0]  alu_result,
  input  logic        alu_zero,
  input  logic        alu_carry,
  output logic [7:0]  ram_data,
  output logic        ram_write_enable,
  output logic [3:0]  ram_addr_write,
  output logic [3:0]  ram_addr0,
  output logic [3:0]  ram_addr1,
  output logic [2:0]  alu_select,
  output logic        busy,
  output logic        flag_zero,
  output logic        flag_carry,
  output logic [15:0] retired_count
);

  if ((READ_LATENCY < 1) || (READ_LATENCY > 15)) begin : g_bad_latency
    $error("alu_sequencer: READ_LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  dest_q, dest_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        we_q, we_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  addr_wr_q, addr_wr_d;
  logic [3:0]  addr0_q, addr0_d;
  logic [3:0]  addr1_q, addr1_d;
  logic [2:0]  sel_q, sel_d;
  logic        fz_q, fz_d;
  logic        fc_q, fc_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dest_d    = dest_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    we_d      = we_q;
    data_d    = data_q;
    addr_wr_d = addr_wr_q;
    addr0_d   = addr0_q;
    addr1_d   = addr1_q;
    sel_d     = sel_q;
    fz_d      = fz_q;
    fc_d      = fc_q;
    case (state_q)
      IDLE: begin
        if (instr_valid && ready_q) begin
          ready_d = 1'b0;
          busy_d  = 1'b1;
          dest_d  = instr[11:8];
          if (instr[15]) begin
            // LOADI skips EXEC: the immediate goes straight to the write port
            state_d   = WB;
            we_d      = 1'b1;
            addr_wr_d = instr[11:8];
            data_d    = instr[7:0];
          end else begin
            state_d = EXEC;
            cnt_d   = 4'(READ_LATENCY - 1);
            sel_d   = instr[14:12];
            addr0_d = instr[7:4];
            addr1_d = instr[3:0];
          end
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d   = WB;
          data_d    = alu_result;
          fz_d      = alu_zero;
          fc_d      = alu_carry;
          we_d      = 1'b1;
          addr_wr_d = dest_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WB: begin
        state_d = IDLE;
        we_d    = 1'b0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        we_d    = 1'b0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dest_q    <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      we_q      <= 1'b0;
      data_q    <= '0;
      addr_wr_q <= '0;
      addr0_q   <= '0;
      addr1_q   <= '0;
      sel_q     <= '0;
      fz_q      <= 1'b0;
      fc_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dest_q    <= dest_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      we_q      <= we_d;
      data_q    <= data_d;
      addr_wr_q <= addr_wr_d;
      addr0_q   <= addr0_d;
      addr1_q   <= addr1_d;
      sel_q     <= sel_d;
      fz_q      <= fz_d;
      fc_q      <= fc_d;
    end
  end

`ifdef ALU_SEQ_RETIRE_COUNT_EN
  logic [15:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (state_q == WB) retired_d = retired_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) retired_q <= '0;
    else          retired_q <= retired_d;
  end

  assign retired_count = retired_q;
`else
  assign retired_count = '0;
`endif

  assign instr_ready      = ready_q;
  assign busy             = busy_q;
  assign ram_write_enable = we_q;
  assign ram_data         = data_q;
  assign ram_addr_write   = addr_wr_q;
  assign ram_addr0        = addr0_q;
  assign ram_addr1        = addr1_q;
  assign alu_select       = sel_q;
  assign flag_zero        = fz_q;
  assign flag_carry       = fc_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench: two sequencers (READ_LATENCY 1 and 3), each with a register-file + pipelined ALU model.
module tb_alu_sequencer;
  localparam int RL0 = 1;
  localparam int RL1 = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] instr = '0;
  logic [1:0]  valid_v = '0;
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_ret [2];

  wire  [1:0]  ready_v, we_v, busy_v, fz_v, fc_v;
  wire  [7:0]  data_v [2];
  wire  [3:0]  awr_v [2];
  wire  [3:0]  a0_v [2];
  wire  [3:0]  a1_v [2];
  wire  [2:0]  sel_v [2];
  wire  [15:0] ret_v [2];

  typedef struct {
    int          k;
    logic [3:0]  addr;
    logic [7:0]  data;
    logic        z;
    logic        c;
    int unsigned wcyc;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [8:0] alu_f(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      3'd0:    alu_f = {1'b0, a} + {1'b0, b};
      3'd1:    alu_f = {1'b0, a} - {1'b0, b};
      3'd2:    alu_f = {1'b0, a & b};
      3'd3:    alu_f = {1'b0, a | b};
      3'd4:    alu_f = {1'b0, a ^ b};
      3'd5:    alu_f = {a, 1'b0};
      3'd6:    alu_f = {a[0], 1'b0, a[7:1]};
      default: alu_f = {1'b0, a};
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dp
    localparam int RL = (g == 0) ? RL0 : RL1;
    logic [7:0] ram [16];
    logic [8:0] pipe [16];
    logic [8:0] comb_res, res;
    logic       ready, we, busy, fz, fc;
    logic [7:0] data;
    logic [3:0] awr, a0, a1;
    logic [2:0] sel;
    logic [15:0] ret;

    assign comb_res = alu_f(sel, ram[a0], ram[a1]);
    if (RL == 1) begin : g_comb
      assign res = comb_res;
    end else begin : g_pipe
      assign res = pipe[RL-2];
    end

    always @(posedge clock) begin
      pipe[0] <= comb_res;
      for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
      if (we) ram[awr] <= data;
    end

    alu_sequencer #(.READ_LATENCY(RL)) u_dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .instr_valid      (valid_v[g]),
      .instr_ready      (ready),
      .instr            (instr),
      .alu_result       (res[7:0]),
      .alu_zero         (res[7:0] == 8'h00),
      .alu_carry        (res[8]),
      .ram_data         (data),
      .ram_write_enable (we),
      .ram_addr_write   (awr),
      .ram_addr0        (a0),
      .ram_addr1        (a1),
      .alu_select       (sel),
      .busy             (busy),
      .flag_zero        (fz),
      .flag_carry       (fc),
      .retired_count    (ret)
    );

    assign ready_v[g] = ready;
    assign we_v[g]    = we;
    assign busy_v[g]  = busy;
    assign fz_v[g]    = fz;
    assign fc_v[g]    = fc;
    assign data_v[g]  = data;
    assign awr_v[g]   = awr;
    assign a0_v[g]    = a0;
    assign a1_v[g]    = a1;
    assign sel_v[g]   = sel;
    assign ret_v[g]   = ret;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write pulse pops one expected write.
  always @(negedge clock) begin : monitor
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (we_v[k] === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: dut%0d wrote %0h to r%0d, expected no write", k, data_v[k], awr_v[k]);
        end else begin
          e = sb.pop_front();
          check("wr_dut", k, e.k);
          check("wr_addr", {28'd0, awr_v[k]}, {28'd0, e.addr});
          check("wr_data", {24'd0, data_v[k]}, {24'd0, e.data});
          check("wr_flags", {30'd0, fz_v[k], fc_v[k]}, {30'd0, e.z, e.c});
          check("wr_cycle", cyc + 1, e.wcyc);
        end
      end
    end
  end

  task automatic check_rst(input int k);
    check("rst_ctl", {we_v[k], awr_v[k], a0_v[k], a1_v[k], sel_v[k], data_v[k]}, '0);
    check("rst_status", {28'd0, ready_v[k], busy_v[k], fz_v[k], fc_v[k]}, 32'h8);
    check("rst_retired", {16'd0, ret_v[k]}, '0);
  endtask

  task automatic issue(input int k, input logic [15:0] w, input bit hold,
                       input logic [7:0] edata, input logic ez, input logic ec);
    int          lat;
    int          n;
    int unsigned acc;
    bit          is_alu;
    exp_t        e;
    is_alu = !w[15];
    lat = is_alu ? ((k == 0) ? RL0 : RL1) + 1 : 1;
    @(negedge clock);
    instr = w;
    valid_v[k] = 1'b1;
    n = 0;
    while (ready_v[k] !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n == 50) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: dut%0d instr_ready=%b, required 1", k, ready_v[k]);
      valid_v[k] = 1'b0;
      return;
    end
    @(posedge clock);
    acc = cyc + 1;
    e.k = k; e.addr = w[11:8]; e.data = edata; e.z = ez; e.c = ec; e.wcyc = acc + lat;
    sb.push_back(e);
    for (int i = 0; i < lat; i++) begin
      @(negedge clock);
      if (!hold) valid_v[k] = 1'b0;
      check("busy_ready", {30'd0, busy_v[k], ready_v[k]}, 32'h2);
      if (is_alu && i < lat - 1) begin
        check("exec_we", {31'd0, we_v[k]}, '0);
        check("exec_rd", {21'd0, a0_v[k], a1_v[k], sel_v[k]}, {21'd0, w[7:4], w[3:0], w[14:12]});
      end
    end
    @(negedge clock);
    valid_v[k] = 1'b0;
`ifdef ALU_SEQ_RETIRE_COUNT_EN
    exp_ret[k] = exp_ret[k] + 16'd1;
`endif
    check("idle_status", {29'd0, busy_v[k], ready_v[k], we_v[k]}, 32'h2);
    check("retired", {16'd0, ret_v[k]}, {16'd0, exp_ret[k]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    exp_ret[0] = '0;
    exp_ret[1] = '0;
    repeat (2) @(negedge clock);
    check_rst(0);
    check_rst(1);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check_rst(0);
    check_rst(1);

    // READ_LATENCY = 1 instance
    issue(0, 16'h8A5C, 0, 8'h5C, 1'b0, 1'b0);
    issue(0, 16'h8180, 0, 8'h80, 1'b0, 1'b0);
    issue(0, 16'h8280, 0, 8'h80, 1'b0, 1'b0);
    issue(0, 16'h0312, 0, 8'h00, 1'b1, 1'b1);  // 0x80+0x80
    issue(0, 16'h8F01, 0, 8'h01, 1'b1, 1'b1);  // LOADI keeps flags
    issue(0, 16'h14FA, 0, 8'hA5, 1'b0, 1'b1);  // 0x01-0x5C borrows
    issue(0, 16'h25A1, 0, 8'h00, 1'b1, 1'b0);  // 0x5C & 0x80
    issue(0, 16'h463A, 0, 8'h5C, 1'b0, 1'b0);  // r3 (just written) ^ 0x5C

    // READ_LATENCY = 3 instance, valid held through EXEC/WB on the ALU ops
    issue(1, 16'h8133, 0, 8'h33, 1'b0, 1'b0);
    issue(1, 16'h82CC, 0, 8'hCC, 1'b0, 1'b0);
    issue(1, 16'h3712, 1, 8'hFF, 1'b0, 1'b0);  // 0x33 | 0xCC
    issue(1, 16'h0871, 1, 8'h32, 1'b0, 1'b1);  // 0xFF + 0x33

    // Reset in the middle of EXEC: r8 must keep 0x32 and no write may occur
    @(negedge clock);
    instr = 16'h7820;
    valid_v[1] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    valid_v[1] = 1'b0;
    check("pre_rst_busy", {31'd0, busy_v[1]}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check_rst(1);
    check_rst(0);
    exp_ret[0] = '0;
    exp_ret[1] = '0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (8) @(negedge clock);
    check("rst_no_write", {24'd0, g_dp[1].ram[8]}, 32'h32);
    check_rst(1);

    issue(0, 16'h8907, 0, 8'h07, 1'b0, 1'b0);
    issue(1, 16'h0912, 0, 8'hFF, 1'b0, 1'b0);  // 0x33 + 0xCC after reset

    repeat (3) @(negedge clock);
    check("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Upstream controller for the register-file + ALU datapath.
- Accepts 16-bit instructions over a valid/ready handshake.
- Decodes each instruction into the RAM read addresses and the ALU select, then writes the ALU result (or an immediate) back into the RAM.
- Registers the ALU zero/carry flags as architectural status.
- Feeds the datapath's data, write_enable, addr_write, addr0, addr1 and select inputs; consumes its result, zero_flag and carry_flag outputs.

Parameters:
- READ_LATENCY, 1, cycles from driving addr0/addr1/select to the ALU result being valid. Legal range 1..15; any other value is an elaboration-time $error.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  instruction present on instr.
- instr_ready  output  1  sequencer can accept an instruction.
- instr  input  16  instruction word.
- alu_result  input  8  ALU result.
- alu_zero  input  1  ALU zero flag.
- alu_carry  input  1  ALU carry flag.
- ram_data  output  8  write data to the RAM.
- ram_write_enable  output  1  RAM write strobe.
- ram_addr_write  output  4  RAM write address.
- ram_addr0  output  4  RAM read port 0 address.
- ram_addr1  output  4  RAM read port 1 address.
- alu_select  output  3  ALU operation select.
- busy  output  1  high in any state other than IDLE.
- flag_zero  output  1  registered zero flag of the last ALU instruction.
- flag_carry  output  1  registered carry flag of the last ALU instruction.
- retired_count  output  16  retired-instruction counter (see Optional Feature).

Behaviour:
- Instruction decode:
  - instr[15]=1 is LOADI: dest=instr[11:8], imm=instr[7:0]; instr[14:12] ignored.
  - instr[15]=0 is ALU: select=instr[14:12], dest=instr[11:8], src0=instr[7:4], src1=instr[3:0].
- All outputs are registered or decoded from registered state only; no combinational path from instr or alu_* to any output.
- Reset (asynchronous, takes effect immediately):
  - State returns to IDLE.
  - All RAM/ALU control outputs, flag_zero, flag_carry, busy and retired_count go to 0.
  - instr_ready goes to 1.
  - An in-flight instruction is dropped and never written.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - On a clock edge with instr_valid && instr_ready, latch instr.
  - ALU instruction goes to EXEC with the wait counter loaded to READ_LATENCY-1; LOADI goes to WB.
  - With instr_valid=0, stay in IDLE.
- EXEC:
  - instr_ready=0.
  - ram_addr0=src0, ram_addr1=src1 and alu_select=select are held stable.
  - The counter decrements each cycle.
  - On the edge where the counter is 0: capture alu_result into the result register, load flag_zero<=alu_zero and flag_carry<=alu_carry, then go to WB.
  - EXEC therefore lasts exactly READ_LATENCY cycles.
- WB (exactly 1 cycle):
  - ram_write_enable=1, ram_addr_write=dest.
  - ram_data = captured result (ALU instruction) or imm (LOADI).
  - Next state is IDLE.
- ram_write_enable is 0 in IDLE and EXEC.
- In IDLE, address, select and data outputs hold their last values.
- Latency from the accept edge to the write edge: ALU instruction READ_LATENCY+1 cycles; LOADI 1 cycle.
- Back-to-back issue: the next instruction is accepted no earlier than the IDLE cycle after WB. A read of a register written by the previous instruction therefore always sees the new value; no forwarding is needed.
- LOADI never changes flag_zero or flag_carry.
- instr and instr_valid are ignored while instr_ready=0. The upstream holds instr until it is accepted.

Optional Feature:
- Macro ALU_SEQ_RETIRE_COUNT_EN.
- Defined: retired_count increments by 1 on every WB cycle (both instruction kinds) and wraps from 0xFFFF to 0x0000. It is cleared by reset.
- Not defined: retired_count is constant 0 and no counter flops are inferred.

Test Plan:
- Reset release, no stimulus -> instr_ready=1, busy=0, ram_write_enable=0, all control outputs 0, flag_zero=flag_carry=0.
- LOADI instr=0x8A5C accepted at edge N -> at cycle N+1: ram_write_enable=1, ram_addr_write=0xA, ram_data=0x5C; at N+2: IDLE, instr_ready=1; flags unchanged.
- Load R1=0x80 and R2=0x80, then ALU instr with select=add, dest=3, src0=1, src1=2, READ_LATENCY=1 -> ram_addr0=1, ram_addr1=2 held for 1 cycle, then WB writes 0x00 to R3; flag_zero=1, flag_carry=1.
- READ_LATENCY=3, ALU instruction -> EXEC lasts exactly 3 cycles and ram_write_enable pulses once, 4 cycles after accept. instr_valid held high throughout is not re-accepted until IDLE.
- Assert reset_n low during EXEC -> outputs clear immediately, no write pulse occurs, and the destination register keeps its old value.
- With ALU_SEQ_RETIRE_COUNT_EN, retired_count preset near wrap by issuing 65537 LOADIs -> retired_count reads 1. Without the macro, retired_count stays 0 throughout.
